// File: rtl/soft_dec_pkg.sv
// rtl/soft_dec_pkg.sv - shared types and constants for the soft-decision decoder front end
//
// Contents:
//   OUT_W, FRAME_LEN       decoder soft-input width and codeword length
//   SOFT_MAX, SOFT_MIN     representable range of one decoder soft value
//   soft_t                 one decoder soft value
//   asm_state_t            frame assembler states
package soft_dec_pkg;

  localparam int OUT_W     = 6;
  localparam int FRAME_LEN = 8;
  localparam int SOFT_MAX  = 31;
  localparam int SOFT_MIN  = -32;

  typedef logic signed [OUT_W-1:0] soft_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/soft_quantizer.sv
// rtl/soft_quantizer.sv - combinational round-and-saturate of one wide soft sample
//
// Ports:
//   d         in   IN_W   signed wide soft sample
//   q         out  OUT_W  rounded, saturated soft value
//   sat_flag  out  1      clamping changed the rounded value
module soft_quantizer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 6,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat_flag
);

  // One guard bit keeps the rounding offset from overflowing the sample.
  localparam int T_W = IN_W + 1;
  localparam logic signed [T_W-1:0] RND   = T_W'(2 ** (SHIFT - 1));
  localparam logic signed [T_W-1:0] T_MAX = T_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [T_W-1:0] T_MIN = T_W'(-(2 ** (OUT_W - 1)));

  logic signed [T_W-1:0] biased;
  logic signed [T_W-1:0] t;

  always_comb begin
    biased   = {d[IN_W-1], d} + RND;
    t        = biased >>> SHIFT;
    q        = t[OUT_W-1:0];
    sat_flag = 1'b0;
    if (t > T_MAX) begin
      q        = T_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (t < T_MIN) begin
      q        = T_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/soft_frame_assembler.sv
// rtl/soft_frame_assembler.sv - quantise serial soft samples and pack them into decoder frames
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       in_data/in_sof valid
//   in_ready       a sample can be accepted this cycle
//   in_data        signed wide soft sample
//   in_sof         sample is index 0 of a new frame
//   frame_valid    frame_data holds a complete frame
//   frame_ready    downstream consumes the frame this cycle
//   frame_data     packed frame, r[k] at bits [k*OUT_W +: OUT_W], r[0] first received
//   sat_cnt        samples clipped by saturation (saturating)
//   drop_cnt       partial frames discarded by resync (saturating)
module soft_frame_assembler
  import soft_dec_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 6,
  parameter int SHIFT     = 2,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_sof,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [FRAME_LEN*OUT_W-1:0] frame_data,
  output logic [CNT_W-1:0]           sat_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int FW    = FRAME_LEN * OUT_W;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  localparam logic [0:0] S_COLLECT = 1'(COLLECT);
  localparam logic [0:0] S_HOLD    = 1'(HOLD);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic [FW-1:0]    out_q, out_d;
  logic             fv_q, fv_d;
  logic [CNT_W-1:0] sat_q, sat_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic signed [OUT_W-1:0] q;
  logic                    sat_flag;
  logic                    accept;
  logic                    resync;
  logic                    complete;
  logic                    slot_free;
  logic                    load;
  logic [IDX_W-1:0]        wr_idx;

  soft_quantizer #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_quant (
    .d       (in_data),
    .q       (q),
    .sat_flag(sat_flag)
  );

  always_comb begin
    in_ready  = (state_q == S_COLLECT);
    accept    = in_valid && in_ready;
    resync    = accept && in_sof && (idx_q != '0);
    // A resync sample restarts the frame at slot 0.
    wr_idx    = resync ? '0 : idx_q;
    complete  = accept && (wr_idx == LAST);
    slot_free = !fv_q || frame_ready;

    asm_d = asm_q;
    if (accept) begin
      asm_d[wr_idx*OUT_W +: OUT_W] = q;
    end

    // In HOLD no sample is accepted, so asm_d is the held frame.
    load = (complete && slot_free) || ((state_q == S_HOLD) && frame_ready);

    state_d = state_q;
    idx_d   = idx_q;
    if (complete) begin
      idx_d   = '0;
      state_d = slot_free ? S_COLLECT : S_HOLD;
    end else if (accept) begin
      idx_d = wr_idx + IDX_W'(1);
    end else if ((state_q == S_HOLD) && frame_ready) begin
      state_d = S_COLLECT;
    end

    out_d = load ? asm_d : out_q;
    if (load) begin
      fv_d = 1'b1;
    end else if (frame_ready) begin
      fv_d = 1'b0;
    end else begin
      fv_d = fv_q;
    end

    sat_d = sat_q;
    if (accept && sat_flag && (sat_q != '1)) begin
      sat_d = sat_q + CNT_W'(1);
    end
    drop_d = drop_q;
    if (resync && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      idx_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      fv_q    <= 1'b0;
      sat_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  assign frame_valid = fv_q;
  assign frame_data  = out_q;
  assign sat_cnt     = sat_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_soft_frame_assembler.sv
// tb/tb_soft_frame_assembler.sv - randomized self-checking bench with a frame-level reference model
module tb_soft_frame_assembler;

  localparam int FL = 8;
  localparam int OW = 6;
  localparam int FW = FL * OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [7:0]    in_data;
  logic          frame_ready;
  logic          in_ready;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [15:0]   sat_cnt;
  logic [15:0]   drop_cnt;

  logic          s_in_ready;
  logic          s_frame_valid;
  logic [FW-1:0] s_frame_data;
  logic [1:0]    s_sat_cnt;
  logic [1:0]    s_drop_cnt;

  soft_frame_assembler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
  );

  soft_frame_assembler #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_sof(in_sof),
    .frame_valid(s_frame_valid), .frame_ready(frame_ready), .frame_data(s_frame_data),
    .sat_cnt(s_sat_cnt), .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: output slot, one waiting frame, samples of the frame being built.
  bit            m_fv;
  logic [FW-1:0] m_out;
  bit            m_pv;
  logic [FW-1:0] m_pend;
  int            m_cur[$];
  int            m_sat;
  int            m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int floor_div4(input int v);
    if (v >= 0) return v / 4;
    return -((-v + 3) / 4);
  endfunction

  function automatic int quant(input int x, output bit clip);
    int t;
    t    = floor_div4(x + 2);
    clip = 1'b0;
    if (t > 31)  begin t = 31;  clip = 1'b1; end
    if (t < -32) begin t = -32; clip = 1'b1; end
    return t;
  endfunction

  function automatic int cap(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_fv = 0; m_out = '0; m_pv = 0; m_pend = '0; m_cur.delete(); m_sat = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit            acc;
    bit            done;
    bit            clip;
    bit            slot_free;
    int            qv;
    int            x;
    logic [FW-1:0] f;
    logic [31:0]   qb;
    acc       = in_valid && !m_pv;
    slot_free = !m_fv || frame_ready;
    done      = 0;
    f         = '0;
    if (acc) begin
      x  = $signed(in_data);
      qv = quant(x, clip);
      if (clip) m_sat++;
      if (in_sof && m_cur.size() != 0) begin
        m_drop++;
        m_cur.delete();
      end
      m_cur.push_back(qv);
      if (m_cur.size() == FL) begin
        for (int k = 0; k < FL; k++) begin
          qb = m_cur[k];
          f[k*OW +: OW] = qb[OW-1:0];
        end
        m_cur.delete();
        done = 1;
      end
    end
    if (done && slot_free) begin
      m_out = f; m_fv = 1;
    end else if (done) begin
      m_pend = f; m_pv = 1;
      if (frame_ready) m_fv = 0;
    end else if (m_pv && frame_ready) begin
      m_out = m_pend; m_pv = 0; m_fv = 1;
    end else if (frame_ready) begin
      m_fv = 0;
    end
  endtask

  task automatic check_cycle();
    chk("in_ready", in_ready, !m_pv);
    chk("frame_valid", frame_valid, m_fv);
    if (m_fv) chk("frame_data", frame_data, m_out);
    chk("sat_cnt", sat_cnt, cap(m_sat, 65535));
    chk("drop_cnt", drop_cnt, cap(m_drop, 65535));
    chk("small_frame_valid", s_frame_valid, m_fv);
    chk("small_sat_cnt", s_sat_cnt, cap(m_sat, 3));
    chk("small_drop_cnt", s_drop_cnt, cap(m_drop, 3));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send(input int x, input bit sof);
    logic [31:0] xv;
    xv       = x;
    in_valid = 1'b1;
    in_data  = xv[7:0];
    in_sof   = sof;
    cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  int pulses;
  int rises[$];
  int ready_drops;
  int v1[8] = '{6, 5, -6, 100, -128, 127, 0, -1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_frame_valid", frame_valid, 1'b0);
    chk("reset_frame_data", frame_data, '0);
    chk("reset_sat_cnt", sat_cnt, '0);
    chk("reset_drop_cnt", drop_cnt, '0);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_in_ready", in_ready, 1'b1);

    // Single frame with known values.
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(v1[i], 1'b0);
    chk("single_valid", frame_valid, 1'b1);
    chk("single_data", frame_data, 48'h0007E067F042);
    chk("single_sat", sat_cnt, 16'd1);
    cycle();

    // Backpressure: 16 back-to-back samples with the output stalled.
    frame_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)) - 128, 1'b0);
    chk("bp_in_ready_hold", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 8'h11;
    repeat (2) cycle();
    in_valid = 1'b0;
    frame_ready = 1'b1;
    cycle();
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_valid", frame_valid, 1'b1);
    cycle();

    // Resync: partial frame of 3, then a fresh frame of 40s.
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)) - 128, 1'b0);
    send(40, 1'b1);
    for (int i = 0; i < 7; i++) send(40, 1'b0);
    chk("resync_drop", drop_cnt, 16'd1);
    chk("resync_data", frame_data, 48'h28A28A28A28A);

    // Streaming: 10 frames with no gaps.
    pulses = 0; ready_drops = 0;
    for (int i = 0; i < 80; i++) begin
      send(int'($urandom_range(0, 255)) - 128, i == 0);
      in_valid = 1'b1;
      if (!in_ready) ready_drops++;
      if (frame_valid) begin
        pulses++;
        rises.push_back(i);
      end
    end
    in_valid = 1'b0;
    chk("stream_ready_drops", ready_drops, 0);
    chk("stream_pulses", pulses, 10);
    if (rises.size() > 0) chk("stream_first_rise", rises[0], 7);
    for (int k = 1; k < rises.size(); k++) chk("stream_gap", rises[k] - rises[k-1], 8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      in_sof      = ($urandom_range(0, 15) == 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0; in_sof = 1'b0; frame_ready = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)) - 128, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", frame_valid, 1'b0);
    chk("async_rst_data", frame_data, '0);
    chk("async_rst_sat", sat_cnt, '0);
    chk("async_rst_drop", drop_cnt, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(127, 1'b0);
    chk("clean_frame_valid", frame_valid, 1'b1);
    chk("clean_frame_drop", drop_cnt, 16'd0);
    chk("clean_frame_sat", sat_cnt, 16'd8);
    chk("small_sat_hold", s_sat_cnt, 2'd3);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
